// File: rtl/fpdiv_pkg.sv
// Shared types for the fpdiv issue block.
//   fpdiv_issue_state_t : issue FSM states
//   fpdiv_req_t         : registered request (operands + divider mode bits)
//   fpdiv_rsp_t         : captured response (result, flags, denorm, timeout, latency)
//   sat_inc()           : 8-bit increment that sticks at all-ones
package fpdiv_pkg;

  localparam int FLAG_W = 5;
  localparam int OP_W   = 64;
  localparam int RM_W   = 3;
  localparam int CNT_W  = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } fpdiv_issue_state_t;

  typedef struct packed {
    logic [OP_W-1:0] op1;
    logic [OP_W-1:0] op2;
    logic [RM_W-1:0] rm;
    logic            op_type;
    logic            p;
    logic            oven;
    logic            unen;
  } fpdiv_req_t;

  typedef struct packed {
    logic [OP_W-1:0]   result;
    logic [FLAG_W-1:0] flags;
    logic              denorm;
    logic              timeout;
    logic [CNT_W-1:0]  cycles;
  } fpdiv_rsp_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/fpdiv_issue_sat_counter.sv
// 8-bit saturating counter with synchronous clear and count enable.
//   clk, reset : clock, asynchronous active-high reset
//   clr        : zero the count (wins over en)
//   en         : advance by one, holding at 8'hFF
//   count      : current value
module sat_counter
  import fpdiv_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= sat_inc(count);
    end
  end

endmodule

// File: rtl/fpdiv_issue.sv
// fpdiv_issue: drives the fpdiv start/done protocol from a valid/ready
// request channel and returns the divider result on a valid/ready response
// channel, together with the measured latency.
//
// Ports
//   clk, reset                 clock, asynchronous active-high reset
//   req_valid/req_ready        request handshake
//   req_op1, req_op2           64-bit operands (single precision in [63:32])
//   req_rm, req_op_type, req_p, req_oven, req_unen   divider mode bits
//   div_op1 .. div_unen        registered operands/mode bits to the divider
//   div_start                  start pulse, START_CYCLES cycles long
//   div_done, div_result, div_flags, div_denorm      divider response
//   rsp_valid/rsp_ready        response handshake
//   rsp_result, rsp_flags, rsp_denorm                captured divider outputs
//   rsp_timeout                response produced by the watchdog
//   rsp_cycles                 edges from acceptance to capture, saturating at 255
//
// Build option: define FPDIV_ISSUE_TIMEOUT_EN to enable the WAIT watchdog
// (TIMEOUT cycles). Without it WAIT blocks until div_done and rsp_timeout is 0.
module fpdiv_issue
  import fpdiv_pkg::*;
#(
  parameter int START_CYCLES = 2,
  parameter int TIMEOUT      = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [OP_W-1:0]   req_op1,
  input  logic [OP_W-1:0]   req_op2,
  input  logic [RM_W-1:0]   req_rm,
  input  logic              req_op_type,
  input  logic              req_p,
  input  logic              req_oven,
  input  logic              req_unen,
  output logic [OP_W-1:0]   div_op1,
  output logic [OP_W-1:0]   div_op2,
  output logic [RM_W-1:0]   div_rm,
  output logic              div_op_type,
  output logic              div_p,
  output logic              div_oven,
  output logic              div_unen,
  output logic              div_start,
  input  logic              div_done,
  input  logic [OP_W-1:0]   div_result,
  input  logic [FLAG_W-1:0] div_flags,
  input  logic              div_denorm,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [OP_W-1:0]   rsp_result,
  output logic [FLAG_W-1:0] rsp_flags,
  output logic              rsp_denorm,
  output logic              rsp_timeout,
  output logic [CNT_W-1:0]  rsp_cycles
);

  // Counters are 8 bits wide, so both limits must fit in 1..255.
  if (START_CYCLES < 1 || START_CYCLES > 255 || TIMEOUT < 1 || TIMEOUT > 255) begin : g_param_check
    $error("fpdiv_issue: START_CYCLES and TIMEOUT must be in 1..255");
  end

  localparam logic [CNT_W-1:0] START_LAST = CNT_W'(START_CYCLES - 1);

  fpdiv_issue_state_t state, state_nxt;
  fpdiv_req_t         req_q;
  fpdiv_rsp_t         rsp_q;

  logic             ready_arm;
  logic             accept;
  logic             capture;
  logic             wait_expired;
  logic [CNT_W-1:0] start_cnt;
  logic [CNT_W-1:0] lat_cnt;

  // ready_arm keeps req_ready low until the first edge after reset release.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ready_arm <= 1'b0;
    end else begin
      ready_arm <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    div_start = 1'b0;
    rsp_valid = 1'b0;
    accept    = 1'b0;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        req_ready = ready_arm;
        if (req_valid && ready_arm) begin
          accept    = 1'b1;
          state_nxt = START;
        end
      end
      START: begin
        // div_done is deliberately not looked at here.
        div_start = 1'b1;
        if (start_cnt == START_LAST) begin
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (div_done || wait_expired) begin
          capture   = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  sat_counter u_start_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (accept),
    .en    (state == START),
    .count (start_cnt)
  );

  // Latency counter: cleared at acceptance, so its saturated increment at
  // the capture edge equals the number of edges since acceptance.
  sat_counter u_lat_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (accept),
    .en    ((state == START) || (state == WAIT)),
    .count (lat_cnt)
  );

`ifdef FPDIV_ISSUE_TIMEOUT_EN
  logic [CNT_W-1:0] wait_cnt;

  // Cleared throughout START so it starts from zero on the first WAIT cycle.
  sat_counter u_wait_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (state == START),
    .en    (state == WAIT),
    .count (wait_cnt)
  );

  assign wait_expired = (wait_cnt == CNT_W'(TIMEOUT - 1));
`else
  assign wait_expired = 1'b0;
`endif

  // Request register: loaded only at acceptance, held through RESP.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_q <= '0;
    end else if (accept) begin
      req_q.op1     <= req_op1;
      req_q.op2     <= req_op2;
      req_q.rm      <= req_rm;
      req_q.op_type <= req_op_type;
      req_q.p       <= req_p;
      req_q.oven    <= req_oven;
      req_q.unen    <= req_unen;
    end
  end

  // Response register: a real done takes priority over a same-cycle watchdog.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_q <= '0;
    end else if (capture) begin
      rsp_q.cycles <= sat_inc(lat_cnt);
      if (div_done) begin
        rsp_q.result  <= div_result;
        rsp_q.flags   <= div_flags;
        rsp_q.denorm  <= div_denorm;
        rsp_q.timeout <= 1'b0;
      end else begin
        rsp_q.result  <= '0;
        rsp_q.flags   <= '0;
        rsp_q.denorm  <= 1'b0;
        rsp_q.timeout <= 1'b1;
      end
    end
  end

  assign div_op1     = req_q.op1;
  assign div_op2     = req_q.op2;
  assign div_rm      = req_q.rm;
  assign div_op_type = req_q.op_type;
  assign div_p       = req_q.p;
  assign div_oven    = req_q.oven;
  assign div_unen    = req_q.unen;

  assign rsp_result  = rsp_q.result;
  assign rsp_flags   = rsp_q.flags;
  assign rsp_denorm  = rsp_q.denorm;
  assign rsp_timeout = rsp_q.timeout;
  assign rsp_cycles  = rsp_q.cycles;

endmodule

// File: tb/tb_fpdiv_issue.sv
// Testbench for fpdiv_issue: vector table, hand-written corner sequences
// (back-to-back, reset in flight, watchdog) and randomized operations.
module tb_fpdiv_issue;

  localparam int START_CYCLES = 2;
  localparam int TIMEOUT      = 32;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [63:0] req_op1, req_op2;
  logic [2:0]  req_rm;
  logic        req_op_type, req_p, req_oven, req_unen;
  logic [63:0] div_op1, div_op2;
  logic [2:0]  div_rm;
  logic        div_op_type, div_p, div_oven, div_unen;
  logic        div_start;
  logic        div_done;
  logic [63:0] div_result;
  logic [4:0]  div_flags;
  logic        div_denorm;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [63:0] rsp_result;
  logic [4:0]  rsp_flags;
  logic        rsp_denorm;
  logic        rsp_timeout;
  logic [7:0]  rsp_cycles;

  int checks = 0;
  int errors = 0;
  int edge_no = 0;

  fpdiv_issue #(.START_CYCLES(START_CYCLES), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op1(req_op1), .req_op2(req_op2), .req_rm(req_rm),
    .req_op_type(req_op_type), .req_p(req_p), .req_oven(req_oven), .req_unen(req_unen),
    .div_op1(div_op1), .div_op2(div_op2), .div_rm(div_rm),
    .div_op_type(div_op_type), .div_p(div_p), .div_oven(div_oven), .div_unen(div_unen),
    .div_start(div_start), .div_done(div_done), .div_result(div_result),
    .div_flags(div_flags), .div_denorm(div_denorm),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_flags(rsp_flags), .rsp_denorm(rsp_denorm),
    .rsp_timeout(rsp_timeout), .rsp_cycles(rsp_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) edge_no <= edge_no + 1;

  typedef struct {
    logic [63:0] op1;
    logic [63:0] op2;
    logic [2:0]  rm;
    logic [3:0]  mode;   // {op_type, p, oven, unen}
    int          delay;  // edges from start falling to done sampled
    int          bp;     // cycles rsp_ready held low in RESP
    logic        spur;   // raise done during START
    logic [63:0] res;
    logic [4:0]  flags;
    logic        den;
    logic [7:0]  exp_cyc;
  } vec_t;

  function automatic vec_t mk(input logic [63:0] op1, input logic [63:0] op2,
                              input logic [2:0] rm, input logic [3:0] mode,
                              input int delay, input int bp, input logic spur,
                              input logic [63:0] res, input logic [4:0] flags,
                              input logic den, input logic [7:0] exp_cyc);
    vec_t v;
    v.op1 = op1; v.op2 = op2; v.rm = rm; v.mode = mode; v.delay = delay;
    v.bp = bp; v.spur = spur; v.res = res; v.flags = flags; v.den = den;
    v.exp_cyc = exp_cyc;
    return v;
  endfunction

  // Reference latency: edges from acceptance to the capture edge, saturated.
  function automatic logic [7:0] ref_cycles(input int delay);
    int e;
    e = START_CYCLES + delay;
    return (e > 255) ? 8'hFF : 8'(e);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(input vec_t v);
    int n;
    int sc;
    logic [63:0] held_res;
    n = 0;
    while (!req_ready && n < 50) begin
      tick();
      n++;
    end
    check("req_ready_wait", req_ready, 1);
    req_valid = 1'b1;
    req_op1 = v.op1; req_op2 = v.op2; req_rm = v.rm;
    {req_op_type, req_p, req_oven, req_unen} = v.mode;
    tick();
    req_valid = 1'b0;
    req_op1 = {$urandom, $urandom};
    req_op2 = {$urandom, $urandom};
    req_rm = 3'($urandom);
    check("div_op1", div_op1, v.op1);
    check("div_op2", div_op2, v.op2);
    check("div_mode", {div_rm, div_op_type, div_p, div_oven, div_unen}, {v.rm, v.mode});
    check("req_ready_busy", req_ready, 0);
    if (v.spur) begin
      div_done = 1'b1; div_result = 64'hDEAD_BEEF_0BAD_F00D; div_flags = 5'h15; div_denorm = 1'b1;
    end
    sc = 0;
    while (div_start && sc < 300) begin
      sc++;
      tick();
      div_done = 1'b0;
    end
    check("start_len", sc, START_CYCLES);
    check("no_early_rsp", rsp_valid, 0);
    for (int i = 1; i < v.delay; i++) tick();
    check("wait_no_rsp", rsp_valid, 0);
    check("wait_hold_op1", div_op1, v.op1);
    div_done = 1'b1; div_result = v.res; div_flags = v.flags; div_denorm = v.den;
    tick();
    div_done = 1'b0; div_result = {$urandom, $urandom}; div_flags = 5'($urandom); div_denorm = 1'($urandom);
    check("rsp_valid", rsp_valid, 1);
    check("rsp_result", rsp_result, v.res);
    check("rsp_flags", rsp_flags, v.flags);
    check("rsp_denorm", rsp_denorm, v.den);
    check("rsp_timeout", rsp_timeout, 0);
    check("rsp_cycles", rsp_cycles, v.exp_cyc);
    held_res = rsp_result;
    rsp_ready = 1'b0;
    for (int i = 0; i < v.bp; i++) begin
      tick();
      check("bp_valid", rsp_valid, 1);
      check("bp_result", rsp_result, held_res);
      check("bp_req_ready", req_ready, 0);
      check("bp_op1", div_op1, v.op1);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("post_hs_valid", rsp_valid, 0);
    check("post_hs_ready", req_ready, 1);
  endtask

  task automatic pulse_reset(input string tag);
    #2 reset = 1'b1;
    #1;
    check({tag, "_div_start"}, div_start, 0);
    check({tag, "_rsp_valid"}, rsp_valid, 0);
    check({tag, "_req_ready"}, req_ready, 0);
    check({tag, "_div_op1"}, div_op1, 0);
    check({tag, "_rsp_result"}, rsp_result, 0);
    check({tag, "_rsp_cycles"}, rsp_cycles, 0);
    repeat (2) @(posedge clk);
    #3 reset = 1'b0;
    #1;
    check({tag, "_ready_before_edge"}, req_ready, 0);
    tick();
    check({tag, "_ready_after"}, req_ready, 1);
  endtask

  // Accept one request and optionally advance into WAIT / RESP.
  task automatic partial_op(input int upto);
    req_valid = 1'b1; req_op1 = {$urandom, $urandom};
    tick();
    req_valid = 1'b0;
    if (upto >= 1) repeat (START_CYCLES + 2) tick();
    if (upto >= 2) begin
      div_done = 1'b1; div_result = 64'h1234_5678_9ABC_DEF0;
      tick();
      div_done = 1'b0;
    end
  endtask

  vec_t tbl[6];
  vec_t rv;

  initial begin
    int last_acc;
    int acc_n;
    int n;
    int e0;
    logic acc;
    logic [63:0] nextop;
    logic [63:0] held;

    reset = 1'b1; req_valid = 1'b0; req_op1 = '0; req_op2 = '0; req_rm = '0;
    req_op_type = 1'b0; req_p = 1'b0; req_oven = 1'b0; req_unen = 1'b0;
    div_done = 1'b0; div_result = '0; div_flags = '0; div_denorm = 1'b0;
    rsp_ready = 1'b0;

    tbl[0] = mk({32'h40400000, 32'h0}, {32'h40000000, 32'h0}, 3'd0, 4'b0000, 10, 0, 1'b0,
                {32'h3FC00000, 32'h0}, 5'h00, 1'b0, 8'd12);
    tbl[1] = mk(64'hFFFF_0000_1234_5678, 64'h0000_FFFF_8765_4321, 3'd7, 4'b1111, 1, 0, 1'b0,
                64'hA5A5_A5A5_5A5A_5A5A, 5'h1F, 1'b1, 8'd3);
    tbl[2] = mk({32'h41200000, 32'h0}, {32'h40A00000, 32'h0}, 3'd1, 4'b1010, 4, 7, 1'b0,
                {32'h40000000, 32'h0}, 5'h01, 1'b0, 8'd6);
    tbl[3] = mk({32'h3F800000, 32'h0}, {32'h40400000, 32'h0}, 3'd2, 4'b0101, 5, 0, 1'b1,
                {32'h3EAAAAAB, 32'h0}, 5'h01, 1'b0, 8'd7);
    tbl[4] = mk(64'h1, 64'h2, 3'd4, 4'b0001, 253, 0, 1'b0, 64'h3, 5'h02, 1'b1, 8'd255);
    tbl[5] = mk(64'h4, 64'h5, 3'd3, 4'b1000, 300, 1, 1'b0, 64'h6, 5'h04, 1'b0, 8'd255);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_req_ready", req_ready, 0);
    check("rst_div_start", div_start, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_div_op1", div_op1, 0);
    check("rst_div_mode", {div_op2, div_rm, div_op_type, div_p, div_oven, div_unen}, 0);
    check("rst_rsp_data", {rsp_result, rsp_flags, rsp_denorm, rsp_timeout, rsp_cycles}, 0);
    #2 reset = 1'b0;
    tick();
    check("rel_req_ready", req_ready, 1);

    for (int i = 0; i < 6; i++) do_op(tbl[i]);

    // Back-to-back with done held high: captures on the first WAIT edge.
    req_valid = 1'b1; rsp_ready = 1'b1; div_done = 1'b1;
    div_result = 64'h0123_4567_89AB_CDEF;
    last_acc = -1; acc_n = 0; held = '0;
    for (int i = 0; i < 40; i++) begin
      acc = req_valid && req_ready;
      nextop = req_op1;
      tick();
      if (acc) begin
        held = nextop;
        if (last_acc >= 0) check("b2b_gap", edge_no - last_acc, START_CYCLES + 3);
        last_acc = edge_no;
        acc_n++;
      end
      if (acc_n > 0) check("b2b_hold_op1", div_op1, held);
      if (rsp_valid) check("b2b_cycles", rsp_cycles, START_CYCLES + 1);
      req_op1 = {$urandom, $urandom};
    end
    check("b2b_accepts", acc_n >= 7, 1);
    req_valid = 1'b0;
    n = 0;
    while (!req_ready && n < 20) begin
      tick();
      n++;
    end
    check("b2b_drain", req_ready, 1);
    div_done = 1'b0; rsp_ready = 1'b0;

    // Reset in START, WAIT and RESP
    partial_op(0);
    check("pre_rst_start", div_start, 1);
    pulse_reset("rst_start");
    partial_op(1);
    check("pre_rst_wait", div_start, 0);
    pulse_reset("rst_wait");
    partial_op(2);
    check("pre_rst_resp", rsp_valid, 1);
    pulse_reset("rst_resp");
    do_op(tbl[0]);

`ifdef FPDIV_ISSUE_TIMEOUT_EN
    // Watchdog: done never rises.
    req_valid = 1'b1; req_op1 = 64'h77;
    tick();
    e0 = edge_no;
    req_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 200) begin
      tick();
      n++;
    end
    check("to_valid", rsp_valid, 1);
    check("to_flag", rsp_timeout, 1);
    check("to_result", rsp_result, 0);
    check("to_flags_den", {rsp_flags, rsp_denorm}, 0);
    check("to_cycles", rsp_cycles, START_CYCLES + TIMEOUT);
    check("to_edges", edge_no - e0, START_CYCLES + TIMEOUT);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("to_idle", req_ready, 1);
`endif

    // Randomized operations against the reference latency model.
    for (int k = 0; k < 25; k++) begin
      rv.op1 = {$urandom, $urandom};
      rv.op2 = {$urandom, $urandom};
      rv.rm = 3'($urandom);
      rv.mode = 4'($urandom);
      rv.delay = int'($urandom_range(1, 12));
      rv.bp = int'($urandom_range(0, 3));
      rv.spur = 1'($urandom);
      rv.res = {$urandom, $urandom};
      rv.flags = 5'($urandom);
      rv.den = 1'($urandom);
      rv.exp_cyc = ref_cycles(rv.delay);
      do_op(rv);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fpdiv_issue.md
# fpdiv_issue

Hardware initiator for the `fpdiv` start/done protocol. It accepts division requests over a valid/ready channel and registers the operands and mode bits. It holds them stable on the divider inputs, pulses `start` for a fixed number of cycles, then waits for `done`. It captures result, flags and denorm, and returns them with a measured latency over a valid/ready response channel, so the divider can sit behind a bus or sequencer rather than a bench.

## Interface
Parameters:
- `START_CYCLES`, 2: cycles `div_start` is held high per operation (≥1).
- `TIMEOUT`, 32: WAIT-state cycle limit before a forced timeout response (only with the timeout macro).

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  block can accept a request.
- `req_op1`, `req_op2`  in  64  operands (single precision in [63:32]).
- `req_rm`  in  3  rounding mode.
- `req_op_type`, `req_p`, `req_oven`, `req_unen`  in  1 each  divider mode bits.
- `div_op1`, `div_op2`  out  64  registered operands to divider.
- `div_rm`  out  3  registered rounding mode.
- `div_op_type`, `div_p`, `div_oven`, `div_unen`  out  1 each  registered mode bits.
- `div_start`  out  1  start to divider.
- `div_done`  in  1  divider result valid.
- `div_result`  in  64  divider result.
- `div_flags`  in  5  divider flags.
- `div_denorm`  in  1  divider denorm.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  consumer accepts response.
- `rsp_result`  out  64  captured result.
- `rsp_flags`  out  5  captured flags.
- `rsp_denorm`  out  1  captured denorm.
- `rsp_timeout`  out  1  response produced by watchdog, not `div_done`.
- `rsp_cycles`  out  8  cycles from first `div_start` to capture, saturating at 255.

## Operation
- States: IDLE, START, WAIT, RESP.
- IDLE: `req_ready`=1. On `req_valid & req_ready`, register all `req_*` into `div_*`, clear the cycle counter, and go to START.
- START: `div_start`=1 for exactly `START_CYCLES` cycles, then go to WAIT. `div_done` is ignored in START.
- WAIT: the first edge with `div_done`=1 captures `div_result`, `div_flags` and `div_denorm` plus the counter into the `rsp_*` registers, sets `rsp_timeout`=0, and goes to RESP.
- RESP: `rsp_valid`=1 and response registers are held stable. On `rsp_valid & rsp_ready`, return to IDLE.
- `div_*` operand and mode outputs stay constant from acceptance until the RESP handshake completes.
- Cycle counter increments every cycle in START and WAIT and saturates at 8'hFF.
- `req_ready` and `rsp_valid` are mutually exclusive, so no request is accepted while a response is pending.

## Timing
- Reset (async assert, sync release): state IDLE. `req_ready`=0 while `reset`=1 and 1 from the first edge after release. `div_start`=0, `rsp_valid`=0, and every `div_*` and `rsp_*` data output is 0.
- Acceptance at edge E0: `div_start` is high for cycles E0+1 … E0+`START_CYCLES`.
- When `div_done` is sampled high at edge Ed, `rsp_valid` is high from Ed+1. `rsp_cycles` = Ed − E0, saturated.
- Minimum turnaround is `START_CYCLES`+3 cycles from acceptance to the next `req_ready`, with `rsp_ready` tied high.
- `div_done` high during START does not capture.
- `reset` mid-operation drops `div_start` and `rsp_valid` immediately. Any in-flight result is discarded.

## Configuration
- `FPDIV_ISSUE_TIMEOUT_EN` defined: if WAIT lasts `TIMEOUT` cycles without `div_done`, go to RESP with `rsp_result`=0, `rsp_flags`=0, `rsp_denorm`=0 and `rsp_timeout`=1.
- `FPDIV_ISSUE_TIMEOUT_EN` undefined: WAIT waits indefinitely, `rsp_timeout` is tied 0, and `TIMEOUT` is unused.

## Structure
- The shared package `fpdiv_pkg` holds:
  - the state enum `fpdiv_issue_state_t`;
  - a request struct (op1, op2, rm, op_type, p, oven, unen);
  - a response struct (result, flags, denorm, timeout, cycles);
  - the flag width constant 5.
- One sub-module, `sat_counter`: an 8-bit saturating counter with clear and enable. It is reused for the START count and the latency/timeout counts.

## Test plan
- Single op, op1=32'h40400000 (3.0), op2=32'h40000000 (2.0), rm=0. Stub divider raises done 10 cycles after start falls with result[63:32]=32'h3FC00000. Required: `div_start` high exactly 2 cycles, `rsp_result[63:32]`=32'h3FC00000, `rsp_cycles`=12, `rsp_timeout`=0.
- Back-to-back requests with `req_valid` held high and `rsp_ready`=1: second acceptance no earlier than 5 cycles after the first. `div_op1` is unchanged between acceptance and the RESP handshake.
- Backpressure: `rsp_ready`=0 for 7 cycles in RESP. `rsp_*` stays stable, `req_ready`=0 throughout, and IDLE is entered the cycle after `rsp_ready`=1.
- Spurious done: `div_done`=1 during START. No capture occurs; capture happens on the later WAIT done.
- Timeout (macro defined, TIMEOUT=32): `div_done` never rises. Required: `rsp_valid` with `rsp_timeout`=1, `rsp_result`=0 and `rsp_cycles`=34.
- Reset asserted in WAIT: `div_start`=0 and `rsp_valid`=0 immediately. After release `req_ready`=1 and a new op completes normally.
